// File: rtl/vec_issue_pkg.sv
// Shared types for the vector issue queue: FSM state and queued entry payload.
`include "vector_processor_defs.svh"

package vec_issue_pkg;

  localparam int unsigned XLEN = `XLEN;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
  } entry_t;

endpackage

// File: rtl/vec_issue_fifo.sv
// Circular-buffer FIFO of issue entries with occupancy count and synchronous flush.
module vec_issue_fifo
  import vec_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  entry_t                     wdata_i,
  input  logic                       pop_i,
  output entry_t                     rdata_c,
  output logic                       full_c,
  output logic                       empty_c,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == '0);
  assign rdata_c = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign do_push = push_i && !full_c && !flush_i;
  assign do_pop  = pop_i && !empty_c && !flush_i;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only occupied slots are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/vector_processor_defs.svh
// Global vector-processor definitions shared by RTL and benches.
`ifndef VECTOR_PROCESSOR_DEFS_SVH
`define VECTOR_PROCESSOR_DEFS_SVH
`ifndef XLEN
`define XLEN 32
`endif
`endif

// File: rtl/vec_issue_queue.sv
// Vector instruction issue queue: buffers offered instructions and issues one at a time,
// retiring each on completion, illegal decode, or wait timeout.
module vec_issue_queue
  import vec_issue_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   flush,
  input  logic                   inst_valid,
  output logic                   inst_ready,
  input  logic [XLEN-1:0]        instruction,
  input  logic [XLEN-1:0]        rs1_data,
  input  logic [XLEN-1:0]        rs2_data,
  output logic [XLEN-1:0]        issue_inst,
  output logic [XLEN-1:0]        issue_rs1,
  output logic [XLEN-1:0]        issue_rs2,
  output logic                   issue_valid,
  input  logic                   is_vec,
  input  logic                   inst_done,
  output logic                   illegal_inst,
  output logic                   timeout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e          state_q, state_d;
  entry_t          issue_q, issue_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            illegal_q, illegal_d;
  logic            timeout_q, timeout_d;
  logic            exit_c, pop_c;
  logic            fifo_full, fifo_empty;
  entry_t          head, wdata;

  assign wdata = '{inst: instruction, rs1: rs1_data, rs2: rs2_data};

  vec_issue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .flush_i (flush),
    .push_i  (inst_valid),
    .wdata_i (wdata),
    .pop_i   (pop_c),
    .rdata_c (head),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .count_o (count)
  );

  assign inst_ready   = !fifo_full;
  assign issue_valid  = (state_q == ST_EXEC);
  assign issue_inst   = issue_q.inst;
  assign issue_rs1    = issue_q.rs1;
  assign issue_rs2    = issue_q.rs2;
  assign illegal_inst = illegal_q;
  assign timeout      = timeout_q;

  // Exit priority: illegal decode, then completion, then timeout.
  always_comb begin
    exit_c     = 1'b0;
    illegal_d  = 1'b0;
    timeout_d  = 1'b0;
    state_d    = state_q;
    issue_d    = issue_q;
    wait_cnt_d = wait_cnt_q;

    if (state_q == ST_EXEC) begin
      if (!is_vec) begin
        exit_c    = 1'b1;
        illegal_d = 1'b1;
      end else if (inst_done) begin
        exit_c    = 1'b1;
      end else if (wait_cnt_q == WW'(TIMEOUT - 1)) begin
        exit_c    = 1'b1;
        timeout_d = 1'b1;
      end
    end

    pop_c = !flush && !fifo_empty && ((state_q == ST_IDLE) || exit_c);

    if (pop_c) begin
      state_d    = ST_EXEC;
      issue_d    = head;
      wait_cnt_d = '0;
    end else if (exit_c) begin
      state_d    = ST_IDLE;
      wait_cnt_d = '0;
    end else if (state_q == ST_EXEC) begin
      wait_cnt_d = wait_cnt_q + WW'(1);
    end

    if (flush) begin
      state_d    = ST_IDLE;
      wait_cnt_d = '0;
      illegal_d  = 1'b0;
      timeout_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      issue_q    <= '0;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      issue_q    <= issue_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_vec_issue_queue.sv
// Directed bench for vec_issue_queue (DEPTH=4, TIMEOUT=8) with hand-computed expectations.
module tb_vec_issue_queue;
  import vec_issue_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;

  logic            clk = 1'b0;
  logic            n_rst;
  logic            flush;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] instruction, rs1_data, rs2_data;
  logic [XLEN-1:0] issue_inst, issue_rs1, issue_rs2;
  logic            issue_valid;
  logic            is_vec;
  logic            inst_done;
  logic            illegal_inst;
  logic            timeout;
  logic [$clog2(DEPTH):0] count;

  int n_checks = 0;
  int n_fail   = 0;

  // OP-V major opcode stands in for the decoder.
  assign is_vec = (issue_inst[6:0] == 7'h57);

  always #5 clk = ~clk;

  vec_issue_queue #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .flush        (flush),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .instruction  (instruction),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .issue_inst   (issue_inst),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .issue_valid  (issue_valid),
    .is_vec       (is_vec),
    .inst_done    (inst_done),
    .illegal_inst (illegal_inst),
    .timeout      (timeout),
    .count        (count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [XLEN-1:0] inst);
    inst_valid  = 1'b1;
    instruction = inst;
    rs1_data    = inst ^ 32'h1111_1111;
    rs2_data    = inst ^ 32'h2222_2222;
  endtask

  initial begin
    n_rst = 1'b0; flush = 1'b0; inst_valid = 1'b0; inst_done = 1'b0;
    instruction = '0; rs1_data = '0; rs2_data = '0;
    #2;
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_issue_valid", 64'(issue_valid), 64'd0);
    check_eq("rst_issue_inst", 64'(issue_inst), 64'd0);
    check_eq("rst_illegal", 64'(illegal_inst), 64'd0);
    check_eq("rst_timeout", 64'(timeout), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    check_eq("ready_after_rst", 64'(inst_ready), 64'd1);

    // Single issue, completion after three EXEC cycles
    offer(32'h0000_5057);
    tick();
    check_eq("t1_count_push", 64'(count), 64'd1);
    check_eq("t1_idle_push", 64'(issue_valid), 64'd0);
    inst_valid = 1'b0;
    tick();
    check_eq("t1_valid_c1", 64'(issue_valid), 64'd1);
    check_eq("t1_inst", 64'(issue_inst), 64'h5057);
    check_eq("t1_rs1", 64'(issue_rs1), 64'h1111_4146);
    check_eq("t1_rs2", 64'(issue_rs2), 64'h2222_7275);
    check_eq("t1_count_pop", 64'(count), 64'd0);
    tick();
    check_eq("t1_valid_c2", 64'(issue_valid), 64'd1);
    tick();
    check_eq("t1_valid_c3", 64'(issue_valid), 64'd1);
    inst_done = 1'b1;
    tick();
    inst_done = 1'b0;
    check_eq("t1_idle_after", 64'(issue_valid), 64'd0);
    check_eq("t1_count_end", 64'(count), 64'd0);

    // Back-to-back issue with inst_done held
    inst_done = 1'b1;
    offer(32'h0000_A057);
    tick();
    check_eq("t2_idle_done_ignored", 64'(issue_valid), 64'd0);
    offer(32'h0000_B057);
    tick();
    inst_valid = 1'b0;
    check_eq("t2_first", 64'(issue_inst), 64'hA057);
    check_eq("t2_first_valid", 64'(issue_valid), 64'd1);
    tick();
    check_eq("t2_second", 64'(issue_inst), 64'hB057);
    check_eq("t2_second_valid", 64'(issue_valid), 64'd1);
    tick();
    inst_done = 1'b0;
    check_eq("t2_idle", 64'(issue_valid), 64'd0);

    // Non-vector instruction dropped, next entry issues
    offer(32'h0000_0013);
    tick();
    offer(32'h0200_0057);
    tick();
    inst_valid = 1'b0;
    check_eq("t3_scalar_issued", 64'(issue_inst), 64'h13);
    check_eq("t3_no_pulse_yet", 64'(illegal_inst), 64'd0);
    tick();
    check_eq("t3_illegal_pulse", 64'(illegal_inst), 64'd1);
    check_eq("t3_next_inst", 64'(issue_inst), 64'h0200_0057);
    check_eq("t3_still_exec", 64'(issue_valid), 64'd1);
    tick();
    check_eq("t3_pulse_single", 64'(illegal_inst), 64'd0);
    check_eq("t3_no_timeout", 64'(timeout), 64'd0);
    inst_done = 1'b1;
    tick();
    inst_done = 1'b0;
    check_eq("t3_idle", 64'(issue_valid), 64'd0);

    // Timeout after TIMEOUT EXEC cycles
    offer(32'h0000_1057);
    tick();
    inst_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("t4_wait_valid_%0d", i), 64'(issue_valid), 64'd1);
      check_eq($sformatf("t4_wait_to_%0d", i), 64'(timeout), 64'd0);
    end
    tick();
    check_eq("t4_timeout_pulse", 64'(timeout), 64'd1);
    check_eq("t4_timeout_idle", 64'(issue_valid), 64'd0);
    check_eq("t4_no_illegal", 64'(illegal_inst), 64'd0);
    tick();
    check_eq("t4_timeout_single", 64'(timeout), 64'd0);

    // Fill while stalled: one in flight plus DEPTH queued, sixth held
    for (int i = 1; i <= 5; i++) begin
      offer(32'h0000_0057 | (32'(i) << 12));
      tick();
    end
    check_eq("t5_full_count", 64'(count), 64'd4);
    check_eq("t5_ready_low", 64'(inst_ready), 64'd0);
    check_eq("t5_head_issued", 64'(issue_inst), 64'h1057);
    offer(32'h0000_6057);
    tick();
    check_eq("t5_held_count", 64'(count), 64'd4);
    check_eq("t5_held_ready", 64'(inst_ready), 64'd0);
    inst_done = 1'b1;
    tick();
    inst_done = 1'b0;
    check_eq("t5_after_pop_inst", 64'(issue_inst), 64'h2057);
    check_eq("t5_after_pop_count", 64'(count), 64'd3);
    check_eq("t5_after_pop_ready", 64'(inst_ready), 64'd1);
    tick();
    inst_valid = 1'b0;
    check_eq("t5_held_pushed", 64'(count), 64'd4);
    inst_done = 1'b1;
    tick();
    inst_done = 1'b0;
    check_eq("t5_third_inst", 64'(issue_inst), 64'h3057);
    check_eq("t5_three_queued", 64'(count), 64'd3);

    // Flush with 3 queued, concurrent push blocked
    flush = 1'b1;
    offer(32'h0000_7057);
    tick();
    flush = 1'b0;
    inst_valid = 1'b0;
    check_eq("t6_flush_count", 64'(count), 64'd0);
    check_eq("t6_flush_idle", 64'(issue_valid), 64'd0);
    check_eq("t6_flush_ready", 64'(inst_ready), 64'd1);
    tick();
    check_eq("t6_stays_idle", 64'(issue_valid), 64'd0);

    // Wrapped pointers after flush, then async reset mid-EXEC
    offer(32'h0000_8057);
    tick();
    inst_valid = 1'b0;
    tick();
    check_eq("t7_issue_after_flush", 64'(issue_inst), 64'h8057);
    #2;
    n_rst = 1'b0;
    #1;
    check_eq("t7_rst_valid", 64'(issue_valid), 64'd0);
    check_eq("t7_rst_inst", 64'(issue_inst), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    check_eq("t7_no_illegal", 64'(illegal_inst), 64'd0);
    check_eq("t7_no_timeout", 64'(timeout), 64'd0);
    check_eq("t7_count", 64'(count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
